// File: rtl/pipeline_skid_stage.sv
// Two-entry skid buffer between a valid/ready producer and consumer.
// in_ready is registered so out_ready never reaches the upstream side combinationally.
module pipeline_skid_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_count
);

   typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;

   localparam logic [CNT_W-1:0] STALL_MAX = '1;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q;
   logic [1:0]        occ_q;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              in_fire, out_fire, stall_cyc;

   // Masking with reset keeps in_ready low during reset yet high right after it.
   assign in_ready    = in_ready_q & ~reset;
   assign out_valid   = (state_q != EMPTY);
   assign out_data    = main_q;
   assign occupancy   = occ_q;
   assign stall_count = stall_q;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;
   assign stall_cyc = out_valid & ~out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = stall_q;
      if (stall_cyc && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + 1'b1;
      end
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = HALF;
                  main_d  = in_data;
               end
            end
            HALF: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d = HALF;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         occ_q      <= 2'd0;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != FULL);
         occ_q      <= state_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage: directed scenarios plus a random run, all
// compared against a queue-based model of a two-deep FIFO with a stall counter.
module tb_pipeline_skid_stage;

   localparam int DW        = 32;
   localparam int CW        = 16;
   localparam int STALL_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [CW-1:0] stall_count;

   logic          s_reset, s_flush, s_in_valid, s_out_ready;
   logic [7:0]    s_in_data;
   logic          s_in_ready, s_out_valid;
   logic [7:0]    s_out_data;
   logic [1:0]    s_occupancy;
   logic [1:0]    s_stall_count;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] mq[$];
   int            m_stall;

   always #5 clk = ~clk;

   pipeline_skid_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .stall_count(stall_count)
   );

   pipeline_skid_stage #(.DATA_W(8), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(s_reset), .flush(s_flush),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .occupancy(s_occupancy), .stall_count(s_stall_count)
   );

   // One clock of the reference model, then compare every output against it.
   task automatic tick();
      bit            m_in_fire, m_out_fire, m_stall_cyc, hold;
      logic [DW-1:0] prev_data;
      m_in_fire   = in_valid && !reset && (mq.size() < 2);
      m_out_fire  = (mq.size() > 0) && out_ready;
      m_stall_cyc = (mq.size() > 0) && !out_ready;
      hold        = m_stall_cyc && !flush && !reset;
      prev_data   = out_data;
      @(posedge clk);
      #1;
      if (reset) begin
         mq.delete();
         m_stall = 0;
      end else begin
         if (m_stall_cyc && m_stall < STALL_MAX) m_stall++;
         if (flush) mq.delete();
         else begin
            if (m_out_fire) void'(mq.pop_front());
            if (m_in_fire) mq.push_back(in_data);
         end
      end
      checks++;
      if (out_valid !== (mq.size() > 0)) begin
         errors++;
         $display("FAIL out_valid: got %b expected %b", out_valid, mq.size() > 0);
      end
      checks++;
      if (occupancy !== 2'(mq.size())) begin
         errors++;
         $display("FAIL occupancy: got %0d expected %0d", occupancy, mq.size());
      end
      checks++;
      if (in_ready !== (!reset && mq.size() < 2)) begin
         errors++;
         $display("FAIL in_ready: got %b expected %b", in_ready, !reset && mq.size() < 2);
      end
      checks++;
      if (stall_count !== CW'(m_stall)) begin
         errors++;
         $display("FAIL stall_count: got %0d expected %0d", stall_count, m_stall);
      end
      if (mq.size() > 0) begin
         checks++;
         if (out_data !== mq[0]) begin
            errors++;
            $display("FAIL out_data: got %h expected %h", out_data, mq[0]);
         end
      end
      if (hold) begin
         checks++;
         if (out_data !== prev_data) begin
            errors++;
            $display("FAIL out_data_stable: got %h expected %h", out_data, prev_data);
         end
      end
   endtask

   task automatic idle_inputs();
      flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (out_data !== '0) begin
         errors++;
         $display("FAIL reset_out_data: got %h expected 0", out_data);
      end
   endtask

   task automatic test_streaming();
      idle_inputs();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
            errors++;
            $display("FAIL stream_data: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, i);
         end
      end
      in_valid = 1'b0;
      tick();
      checks++;
      if (stall_count !== '0) begin
         errors++;
         $display("FAIL stream_stall: got %0d expected 0", stall_count);
      end
   endtask

   task automatic test_backpressure();
      logic [CW-1:0] s0;
      idle_inputs();
      s0 = stall_count;
      in_valid = 1'b1; in_data = 32'hA; tick();
      in_data = 32'hB; tick();
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready);
      end
      tick();
      out_ready = 1'b1;
      checks++;
      if (out_data !== 32'hA) begin
         errors++;
         $display("FAIL bp_first: got %h expected a", out_data);
      end
      tick();
      checks++;
      if (out_data !== 32'hB || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_second: got v=%b d=%h expected v=1 d=b", out_valid, out_data);
      end
      tick();
      checks++;
      if (stall_count !== s0 + CW'(2)) begin
         errors++;
         $display("FAIL bp_stall: got %0d expected %0d", stall_count, s0 + CW'(2));
      end
   endtask

   task automatic test_flush();
      bit seen_c;
      idle_inputs();
      in_valid = 1'b1; in_data = 32'hA; tick();
      in_data = 32'hB; tick();
      flush = 1'b1; in_data = 32'hC; tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         errors++;
         $display("FAIL flush_empty: got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy);
      end
      out_ready = 1'b1;
      seen_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (out_valid && out_data == 32'hC) seen_c = 1'b1;
      end
      checks++;
      if (seen_c) begin
         errors++;
         $display("FAIL flush_discard: got c output expected none");
      end
   endtask

   task automatic test_reset_full();
      idle_inputs();
      in_valid = 1'b1; in_data = 32'h11; tick();
      in_data = 32'h22; tick();
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 ||
          stall_count !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_full: got v=%b d=%h occ=%0d st=%0d rdy=%b expected 0 0 0 0 1",
                  out_valid, out_data, occupancy, stall_count, in_ready);
      end
   endtask

   task automatic test_random();
      idle_inputs();
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(1) == 1);
         out_ready = ($urandom_range(1) == 1);
         in_data   = $urandom;
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_saturation();
      int exp_st;
      s_flush = 1'b0; s_out_ready = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h0;
      s_reset = 1'b1;
      @(posedge clk); #1;
      s_reset = 1'b0;
      s_in_valid = 1'b1; s_in_data = 8'h5A;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         exp_st = (k < 3) ? k : 3;
         checks++;
         if (s_stall_count !== 2'(exp_st) || s_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL sat_count[%0d]: got st=%0d v=%b expected st=%0d v=1",
                     k, s_stall_count, s_out_valid, exp_st);
         end
      end
   endtask

   initial begin
      m_stall = 0;
      s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_reset_full();
      test_random();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_skid_stage.md
PIPELINE_SKID_STAGE -- requirements
Module: pipeline_skid_stage

Interface
REQ-001 The module SHALL have a parameter DATA_W, default 32, giving the payload width in bits (legal values 1..512).
REQ-002 The module SHALL have a parameter CNT_W, default 16, giving the stall counter width in bits (legal values 2..32).
REQ-003 The module SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have a port flush, input, 1 bit: discards all held entries at the next edge.
REQ-006 The module SHALL have a port in_valid, input, 1 bit: the upstream payload is valid.
REQ-007 The module SHALL have a port in_ready, output, 1 bit: the stage can accept a payload this cycle.
REQ-008 The module SHALL have a port in_data, input, DATA_W bits: the upstream payload.
REQ-009 The module SHALL have a port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-010 The module SHALL have a port out_ready, input, 1 bit: downstream accepts out_data this cycle.
REQ-011 The module SHALL have a port out_data, output, DATA_W bits: the oldest held payload.
REQ-012 The module SHALL have a port occupancy, output, 2 bits: number of held entries (0..2).
REQ-013 The module SHALL have a port stall_count, output, CNT_W bits: count of back-pressured output cycles.

Function
REQ-014 The module SHALL hold up to two entries: a main register driving out_data and a skid register.
REQ-015 The module SHALL have three states: EMPTY (0 entries), HALF (main valid) and FULL (main and skid valid).
REQ-016 in_ready SHALL be a registered signal equal to 1 in EMPTY and HALF and 0 in FULL, with no combinational path from out_ready.
REQ-017 An input fire (in_fire) SHALL occur when in_valid && in_ready; an output fire (out_fire) SHALL occur when out_valid && out_ready.
REQ-018 out_valid SHALL be 1 in HALF and FULL; out_data SHALL equal the main register.
REQ-019 In EMPTY, an in_fire SHALL move the state to HALF with main <= in_data.
REQ-020 In HALF, in_fire with out_fire SHALL stay in HALF with main <= in_data.
REQ-021 In HALF, in_fire without out_fire SHALL move the state to FULL with skid <= in_data and main unchanged.
REQ-022 In HALF, out_fire without in_fire SHALL move the state to EMPTY.
REQ-023 In FULL, out_fire SHALL move the state to HALF with main <= skid; without out_fire the state SHALL stay FULL with both registers unchanged.
REQ-024 Latency from in_fire to out_valid SHALL be 1 cycle when the stage is EMPTY, and the stage SHALL sustain 1 transfer per cycle while out_ready=1.
REQ-025 Entries SHALL leave the stage in strict FIFO order; no entry SHALL be duplicated or dropped except by flush.
REQ-026 When flush=1, the next state SHALL be EMPTY, and a payload presented with in_fire in the same cycle SHALL be discarded.
REQ-027 Priority SHALL be reset > flush > normal handshake.
REQ-028 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-029 occupancy SHALL equal 0, 1 or 2 for EMPTY, HALF or FULL respectively, and SHALL be registered.
REQ-030 stall_count SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-031 flush SHALL NOT clear stall_count; a stall cycle coincident with flush SHALL still be counted.

Reset
REQ-032 On a clk edge with reset=1, the state SHALL become EMPTY, main and skid SHALL be 0, and stall_count SHALL be 0.
REQ-033 While reset=1, in_ready SHALL be 0; it SHALL be 1 in the first cycle after reset is deasserted.
REQ-034 Reset asserted mid-operation in FULL SHALL discard both entries, with out_valid=0 in the cycle after the reset edge.
REQ-035 After reset, out_valid SHALL be 0, out_data SHALL be 0 and occupancy SHALL be 0.

Verification
REQ-036 Streaming: 8 payloads 0x1..0x8 presented back-to-back with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles starting 1 cycle after the first, and stall_count=0.
REQ-037 Back-pressure: send 0xA then 0xB with out_ready=0 -> occupancy=2 and in_ready=0; raise out_ready -> output 0xA then 0xB, and stall_count increases by 1 for each cycle out_ready was held low.
REQ-038 Flush: with FULL holding 0xA and 0xB, assert flush together with in_valid carrying 0xC -> next cycle out_valid=0, occupancy=0, and 0xC is never output.
REQ-039 Saturation: with CNT_W=2, hold out_valid=1 and out_ready=0 for 6 cycles -> stall_count reads 3 and stays at 3.
REQ-040 Reset in FULL: hold 0x11 and 0x22, assert reset for 1 cycle -> out_valid=0, out_data=0, occupancy=0, stall_count=0, and in_ready=1 in the following cycle.
REQ-041 Random: random in_valid and out_ready at 50% each over 10000 cycles, checked against a scoreboard -> the output sequence equals the input sequence with no loss or duplication, and the stability rule REQ-028 holds.
